// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the multi-chip-select SPI master.
//   spi_state_e    : transfer state machine encoding (IDLE/SETUP/XFER/HOLD)
//   spi_mode_t     : SPI mode captured per transfer (cpol, cpha, lsb_first)
//   spi_cs_width   : width of the slave-index field for a given CS count
//   spi_edge_width : width of a counter able to index every SCLK edge
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    function automatic int spi_cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    function automatic int spi_edge_width(input int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Timing core of the SPI master: a half-period counter and an SCLK edge
// index counter.
//   clk, rstn : system clock, asynchronous active-low reset
//   i_run     : high while a transfer is in progress (any non-IDLE state)
//   i_xfer    : high while SCLK is toggling (XFER state)
//   i_div     : latched half-period length D in clk cycles (>= 1)
//   o_tick    : last cycle of a D-cycle period (any running state)
//   o_lead    : tick that produces an odd SCLK edge (1,3,..)
//   o_trail   : tick that produces an even SCLK edge (2,4,..)
//   o_done    : tick that produces the final SCLK edge of the word
// ---------------------------------------------------------------------------
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_run,
    input  logic             i_xfer,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_lead,
    output logic             o_trail,
    output logic             o_done
);

    localparam int EDGE_W = spi_edge_width(DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;
    logic              w_tick;

    // The counter restarts at every period boundary so SETUP, each SCLK
    // half-period and HOLD all last exactly D cycles.
    assign w_tick = i_run && (r_cnt == (i_div - DIV_W'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!i_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // r_edge holds the zero-based index of the next SCLK edge to produce.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_edge <= '0;
        end else if (!i_xfer) begin
            r_edge <= '0;
        end else if (w_tick) begin
            r_edge <= r_edge + EDGE_W'(1);
        end
    end

    assign o_tick  = w_tick;
    assign o_lead  = w_tick && i_xfer && !r_edge[0];
    assign o_trail = w_tick && i_xfer &&  r_edge[0];
    assign o_done  = o_trail && (r_edge == LAST_EDGE);

endmodule

// File: rtl/spi_master_mc.sv
// ---------------------------------------------------------------------------
// spi_master_mc
// SPI master with per-transfer mode/divider and NUM_CS chip selects.
// A request is accepted when tx_valid && tx_ready; the word then runs
// through SETUP (D cycles), XFER (2*DATA_W*D cycles) and HOLD (D cycles),
// and rx_valid pulses in the first IDLE cycle afterwards.
// Ports:
//   clk, rstn           : system clock, asynchronous active-low reset
//   cfg_div             : SCLK half-period D in clk cycles (0 behaves as 1)
//   cfg_cpol, cfg_cpha  : SPI clock polarity / phase
//   cfg_lsb_first       : bit order for both directions
//   tx_valid, tx_ready  : request handshake
//   tx_data, tx_cs      : word to send and target slave index
//   rx_valid, rx_data   : one-cycle receive strobe and held received word
//   busy                : high whenever the block is not IDLE
//   sclk, mosi, miso    : SPI bus
//   cs_n                : active-low chip selects
// ---------------------------------------------------------------------------
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 10
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic                            cfg_cpol,
    input  logic                            cfg_cpha,
    input  logic                            cfg_lsb_first,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [DATA_W-1:0]               tx_data,
    input  logic [spi_cs_width(NUM_CS)-1:0] tx_cs,
    output logic                            rx_valid,
    output logic [DATA_W-1:0]               rx_data,
    output logic                            busy,
    output logic                            sclk,
    output logic                            mosi,
    input  logic                            miso,
    output logic [NUM_CS-1:0]               cs_n
);

    localparam int CS_W = spi_cs_width(NUM_CS);

    spi_state_e        r_state;
    spi_state_e        w_state_next;
    logic              r_rdy_en;
    spi_mode_t         r_mode;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_cs_n;

    logic              w_accept;
    logic [DIV_W-1:0]  w_div_eff;
    logic [NUM_CS-1:0] w_cs_dec;
    logic              w_tick;
    logic              w_lead;
    logic              w_trail;
    logic              w_done;
    logic              w_in_bit;
    logic [DATA_W-1:0] w_in_rest;
    logic              w_tx_bit;
    logic [DATA_W-1:0] w_tx_rest;
    logic [DATA_W-1:0] w_rx_next;
    logic              w_sample;
    logic              w_shift;

    // -----------------------------------------------------------------------
    // Handshake and request decode
    // -----------------------------------------------------------------------
    // r_rdy_en keeps tx_ready low until the first clock after reset release.
    assign tx_ready  = (r_state == ST_IDLE) && r_rdy_en;
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = tx_valid && tx_ready;
    assign w_div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

    // An out-of-range index matches no bit, so every select stays high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = (tx_cs != CS_W'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Timing core
    // -----------------------------------------------------------------------
    spi_sclk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_sclk_gen (
        .clk     (clk),
        .rstn    (rstn),
        .i_run   (r_state != ST_IDLE),
        .i_xfer  (r_state == ST_XFER),
        .i_div   (r_div),
        .o_tick  (w_tick),
        .o_lead  (w_lead),
        .o_trail (w_trail),
        .o_done  (w_done)
    );

    // -----------------------------------------------------------------------
    // Shift helpers: the outgoing bit always sits at the end selected by
    // the bit order, and the register moves toward that end.
    // -----------------------------------------------------------------------
    always_comb begin
        w_in_bit  = cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        w_in_rest = cfg_lsb_first ? (tx_data >> 1) : (tx_data << 1);
        w_tx_bit  = r_mode.lsb_first ? r_tx_sh[0] : r_tx_sh[DATA_W-1];
        w_tx_rest = r_mode.lsb_first ? (r_tx_sh >> 1) : (r_tx_sh << 1);
        w_rx_next = r_mode.lsb_first ? {miso, r_rx_sh[DATA_W-1:1]}
                                     : {r_rx_sh[DATA_W-2:0], miso};
    end

    // CPHA=0 samples on odd edges and shifts on even edges except the last;
    // CPHA=1 shifts on odd edges (first bit appears at edge 1), samples on even.
    assign w_sample = r_mode.cpha ? w_trail : w_lead;
    assign w_shift  = r_mode.cpha ? w_lead  : (w_trail && !w_done);

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_SETUP;
            ST_SETUP: if (w_tick)   w_state_next = ST_XFER;
            ST_XFER:  if (w_done)   w_state_next = ST_HOLD;
            ST_HOLD:  if (w_tick)   w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy_en   <= 1'b0;
            r_mode     <= '0;
            r_div      <= DIV_W'(1);
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_rdy_en   <= 1'b1;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Idle SCLK follows the live polarity input.
                    r_sclk <= cfg_cpol;
                    r_mosi <= 1'b0;
                    if (w_accept) begin
                        r_mode  <= '{cpol: cfg_cpol, cpha: cfg_cpha,
                                     lsb_first: cfg_lsb_first};
                        r_div   <= w_div_eff;
                        r_cs_n  <= w_cs_dec;
                        r_rx_sh <= '0;
                        if (cfg_cpha) begin
                            r_tx_sh <= tx_data;
                            r_mosi  <= 1'b0;
                        end else begin
                            // CPHA=0 needs the first bit valid before edge 1.
                            r_tx_sh <= w_in_rest;
                            r_mosi  <= w_in_bit;
                        end
                    end
                end
                ST_SETUP: begin
                    r_sclk <= r_mode.cpol;
                end
                ST_XFER: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                    end
                    // miso is captured on the same clk edge that registers
                    // the sample edge onto sclk.
                    if (w_sample) begin
                        r_rx_sh <= w_rx_next;
                    end
                    if (w_shift) begin
                        r_mosi  <= w_tx_bit;
                        r_tx_sh <= w_tx_rest;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n     <= '1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                    end
                end
                default: begin
                    r_cs_n <= '1;
                end
            endcase
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_master_mc.sv
// ---------------------------------------------------------------------------
// tb_spi_master_mc
// Self-checking bench for spi_master_mc (DATA_W=8, NUM_CS=3 so that an
// out-of-range slave index is representable). A negedge monitor counts
// SCLK edges, collects mosi at every sample edge and plays a slave that
// returns a chosen word (or loops mosi back).
// ---------------------------------------------------------------------------
module tb_spi_master_mc;

    localparam int DW  = 8;
    localparam int NCS = 3;
    localparam int DVW = 10;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [DVW-1:0] cfg_div = '0;
    logic           cfg_cpol = 1'b0;
    logic           cfg_cpha = 1'b0;
    logic           cfg_lsb_first = 1'b0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DW-1:0]  tx_data = '0;
    logic [1:0]     tx_cs = '0;
    logic           rx_valid;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic [NCS-1:0] cs_n;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // expectations for the transfer in flight
    bit       loop_en = 1'b1;
    logic     slave_bit = 1'b0;
    logic [7:0] sword_cur = '0;
    bit       exp_cpha, exp_lsb, exp_cpol;
    logic [7:0] exp_data, exp_rx;
    logic [2:0] exp_cs;
    int       exp_d;
    int       h_cyc;

    // monitor results
    bit         mon_active = 1'b0;
    int         mon_edges = 0;
    logic [7:0] mon_mosi_word = '0;
    logic [2:0] mon_cs = '1;
    bit         cs_bad = 1'b0;
    logic       mon_sclk0 = 1'b0;
    logic       mon_mosi0 = 1'b0;
    logic       prev_sclk = 1'b0;

    assign miso = loop_en ? mosi : slave_bit;

    spi_master_mc #(
        .DATA_W (DW),
        .NUM_CS (NCS),
        .DIV_W  (DVW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_div       (cfg_div),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_lsb_first (cfg_lsb_first),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_cs         (tx_cs),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .busy          (busy),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .cs_n          (cs_n)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // SCLK edge monitor and slave model
    initial begin
        int k;
        int idx;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    mon_cs     = cs_n;
                    mon_sclk0  = sclk;
                    mon_mosi0  = mosi;
                    prev_sclk  = sclk;
                end else if (sclk !== prev_sclk) begin
                    prev_sclk = sclk;
                    mon_edges = mon_edges + 1;
                    k = mon_edges;
                    if (((k % 2) == 1) != exp_cpha) begin
                        idx = exp_cpha ? (k / 2 - 1) : ((k - 1) / 2);
                        if (idx >= 0 && idx < 8)
                            mon_mosi_word[exp_lsb ? idx : 7 - idx] = mosi;
                    end else if (k < 16) begin
                        idx = exp_cpha ? ((k - 1) / 2) : (k / 2);
                        if (idx >= 0 && idx < 8)
                            slave_bit = sword_cur[exp_lsb ? idx : 7 - idx];
                    end
                end
                if (cs_n !== mon_cs) cs_bad = 1'b1;
            end else begin
                mon_active = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] data, input int cs, input int div,
                              input bit cpol, input bit cpha, input bit lsb,
                              input bit loop, input logic [7:0] sw, input bit no_wait);
        if (!no_wait) @(negedge clk);
        cfg_div       = div[DVW-1:0];
        cfg_cpol      = cpol;
        cfg_cpha      = cpha;
        cfg_lsb_first = lsb;
        tx_data       = data;
        tx_cs         = cs[1:0];
        tx_valid      = 1'b1;
        exp_cpha  = cpha;
        exp_lsb   = lsb;
        exp_cpol  = cpol;
        exp_data  = data;
        exp_d     = (div == 0) ? 1 : div;
        exp_cs    = (cs < NCS) ? ~(3'b001 << cs) : 3'b111;
        exp_rx    = loop ? data : sw;
        loop_en   = loop;
        sword_cur = sw;
        slave_bit = sw[lsb ? 0 : 7];
        mon_edges = 0;
        mon_mosi_word = '0;
        cs_bad    = 1'b0;
        mon_active = 1'b0;
        chk("ready_at_req", 32'(tx_ready), 32'd1);
        h_cyc = cyc;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        // configuration changes after acceptance must not disturb the word
        cfg_div       = DVW'($urandom_range(0, 5));
        cfg_cpha      = 1'($urandom);
        cfg_lsb_first = 1'($urandom);
        cfg_cpol      = 1'($urandom);
    endtask

    task automatic finish_xfer(input bit chain);
        int  waited;
        bit  got;
        logic first_bit;
        waited = 0;
        got = 1'b0;
        while (waited < 3000) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            waited = waited + 1;
        end
        if (!got) begin
            chk("rx_timeout", 32'd0, 32'd1);
            return;
        end
        first_bit = exp_data[exp_lsb ? 0 : 7];
        chk("latency",     32'(cyc - h_cyc), 32'(1 + (2 * DW + 2) * exp_d));
        chk("rx_data",     32'(rx_data), 32'(exp_rx));
        chk("mosi_bits",   32'(mon_mosi_word), 32'(exp_data));
        chk("sclk_edges",  32'(mon_edges), 32'(2 * DW));
        chk("cs_n_xfer",   32'(mon_cs), 32'(exp_cs));
        chk("cs_n_stable", 32'(cs_bad), 32'd0);
        chk("sclk_setup",  32'(mon_sclk0), 32'(exp_cpol));
        if (!exp_cpha) chk("mosi_first", 32'(mon_mosi0), 32'(first_bit));
        chk("cs_n_gap",    32'(cs_n), 32'h7);
        chk("sclk_idle",   32'(sclk), 32'(exp_cpol));
        chk("mosi_idle",   32'(mosi), 32'd0);
        chk("busy_idle",   32'(busy), 32'd0);
        $display("[TB] xfer tx=%02h D=%0d cpol=%0d cpha=%0d lsb=%0d cs_n=%03b rx=%02h exp_rx=%02h lat=%0d",
                 exp_data, exp_d, exp_cpol, exp_cpha, exp_lsb, mon_cs, rx_data, exp_rx, cyc - h_cyc);
        if (!chain) begin
            @(negedge clk);
            chk("rx_pulse_width", 32'(rx_valid), 32'd0);
            chk("rx_hold",        32'(rx_data), 32'(exp_rx));
        end
    endtask

    initial begin
        int w;
        int pulses;
        // reset state
        #12;
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_cs_n",     32'(cs_n), 32'h7);
        chk("rst_sclk",     32'(sclk), 32'd0);
        chk("rst_mosi",     32'(mosi), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data",  32'(rx_data), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_before_clk", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_clk", 32'(tx_ready), 32'd1);

        // idle SCLK tracks cfg_cpol one cycle later
        @(negedge clk);
        cfg_cpol = 1'b1;
        #1;
        chk("idle_cpol_latency", 32'(sclk), 32'd0);
        @(negedge clk);
        chk("idle_cpol_track", 32'(sclk), 32'd1);
        cfg_cpol = 1'b0;
        @(negedge clk);

        // mode 0, D=2, loopback
        start_xfer(8'hA5, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        finish_xfer(1'b0);
        // mode 3, LSB first, D=1, slave returns 0x81
        start_xfer(8'h3C, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0);
        finish_xfer(1'b0);
        // divider 0 behaves as 1, out-of-range slave index
        start_xfer(8'($urandom), 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        finish_xfer(1'b0);

        // back-to-back: valid held high through the first transfer
        start_xfer(8'h11, 2, 1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'h22;
        finish_xfer(1'b1);
        start_xfer(8'h22, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        finish_xfer(1'b0);

        // reset in the middle of XFER
        start_xfer(8'hC3, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        w = 0;
        while (mon_edges < 7 && w < 500) begin
            @(negedge clk);
            w = w + 1;
        end
        chk("edge7_reached", 32'(mon_edges >= 7), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_cs_n",     32'(cs_n), 32'h7);
        chk("midrst_sclk",     32'(sclk), 32'd0);
        chk("midrst_mosi",     32'(mosi), 32'd0);
        chk("midrst_busy",     32'(busy), 32'd0);
        chk("midrst_ready",    32'(tx_ready), 32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_rx_data",  32'(rx_data), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midrst_ready_hold", 32'(tx_ready), 32'd0);
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (rx_valid === 1'b1) pulses = pulses + 1;
        end
        chk("no_rx_after_rst", 32'(pulses), 32'd0);
        start_xfer(8'h5A, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        finish_xfer(1'b0);

        // randomized transfers
        for (int i = 0; i < 12; i++) begin
            start_xfer(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), 1'b0);
            finish_xfer(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
